// File: rtl/blink_pkg.sv
// Shared encodings for the blink detector.
// Mode values are visible to control logic and self-test.
package blink_pkg;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_STEADY_LO = 3'd1,
      S_STEADY_HI = 3'd2,
      S_EDGE1     = 3'd3,
      S_BLINK     = 3'd4
   } state_t;

endpackage

// File: rtl/blink_detector_sync_edge.sv
// Two-flop synchronizer plus previous-value flop.
// Flags any change of the synchronized level.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic edge_det
);

   logic m_q;
   logic s_q;
   logic p_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q <= 1'b0;
         s_q <= 1'b0;
         p_q <= 1'b0;
      end else begin
         m_q <= din;
         s_q <= m_q;
         p_q <= s_q;
      end
   end

   assign level    = s_q;
   assign edge_det = s_q ^ p_q;

endmodule

// File: rtl/blink_detector.sv
// Classifies a light signal as off, solid on or blinking
// and reports the latest measured half-period.
module blink_detector
   import blink_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int SOLID_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             light_in,
   output logic [1:0]       mode,
   output logic [CNT_W-1:0] half_period,
   output logic             period_valid,
   output logic             mode_changed
);

   localparam logic [CNT_W-1:0] SOLID    = CNT_W'(SOLID_CYCLES);
   localparam logic [CNT_W-1:0] SOLID_M1 = CNT_W'(SOLID_CYCLES - 1);

   logic             level;
   logic             edge_det;
   logic             timeout;
   logic             pv_d;
   logic [CNT_W-1:0] run_cnt;
   logic [1:0]       mode_d;
   logic [1:0]       mode_prev;
   state_t           state_q;
   state_t           state_d;

   sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .din      (light_in),
      .level    (level),
      .edge_det (edge_det)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt <= '0;
      end else if (edge_det) begin
         run_cnt <= CNT_W'(1);
      end else if (run_cnt < SOLID) begin
         run_cnt <= run_cnt + CNT_W'(1);
      end
   end

   assign timeout = !edge_det && (run_cnt == SOLID_M1);

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         timeout: begin
            state_d = level ? S_STEADY_HI : S_STEADY_LO;
         end
         edge_det: begin
            if (state_q == S_EDGE1 || state_q == S_BLINK)
               state_d = S_BLINK;
            else
               state_d = S_EDGE1;
         end
         default: state_d = state_q;
      endcase
   end

   // EDGE1 is a single unconfirmed edge, so it keeps the prior mode
   always_comb begin
      mode_d = mode;
      case (state_d)
         S_IDLE,
         S_STEADY_LO: mode_d = MODE_OFF;
         S_STEADY_HI: mode_d = MODE_ON;
         S_BLINK:     mode_d = MODE_BLINK;
         default:     mode_d = mode;
      endcase
   end

   assign pv_d = edge_det &&
                 (state_q == S_EDGE1 || state_q == S_BLINK);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         mode         <= MODE_OFF;
         mode_prev    <= MODE_OFF;
         half_period  <= '0;
         period_valid <= 1'b0;
         mode_changed <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode         <= mode_d;
         mode_prev    <= mode;
         period_valid <= pv_d;
         mode_changed <= (mode != mode_prev);
         if (pv_d)
            half_period <= run_cnt;
      end
   end

endmodule

// File: tb/tb_blink_detector.sv
// Randomized bench for blink_detector against a
// timestamp-based behavioural model.
module tb_blink_detector;

   localparam int CNT_W = 8;
   localparam int SOLID = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             light_in = 1'b0;
   logic [1:0]       mode;
   logic [CNT_W-1:0] half_period;
   logic             period_valid;
   logic             mode_changed;

   int n_checks = 0;
   int n_fail   = 0;
   int n_mc     = 0;
   int n_pv     = 0;
   int snap_mc;

   blink_detector #(
      .CNT_W        (CNT_W),
      .SOLID_CYCLES (SOLID)
   ) dut (
      .clk          (clk),
      .reset        (rst_n),
      .light_in     (light_in),
      .mode         (mode),
      .half_period  (half_period),
      .period_valid (period_valid),
      .mode_changed (mode_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // model: time since last edge, edges in current burst,
   // level seen at the last steady declaration
   int cyc = 0;
   int r = 0;
   bit fresh = 1'b1;
   int burst = 0;
   bit shi = 1'b0;
   bit m = 1'b0, s = 1'b0, p = 1'b0;
   bit e, to;
   int hp_m = 0;
   bit pv_m = 1'b0;
   int mode_m = 0;
   int mprev = 0;
   bit mc_m = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fresh = 1'b1; burst = 0; shi = 1'b0;
         m = 1'b0; s = 1'b0; p = 1'b0;
         hp_m = 0; pv_m = 1'b0;
         mode_m = 0; mprev = 0; mc_m = 1'b0;
      end else begin
         if (fresh) begin r = cyc; fresh = 1'b0; end
         e  = (s != p);
         to = !e && (cyc - r == SOLID - 1);
         pv_m = e && (burst > 0);
         if (e) begin
            if (burst > 0)
               hp_m = (cyc - r < SOLID) ? cyc - r : SOLID;
            burst = (burst > 0) ? 2 : 1;
            r = cyc;
         end else if (to) begin
            burst = 0;
            shi = s;
         end
         mc_m = (mode_m != mprev);
         mprev = mode_m;
         mode_m = (burst == 2) ? 2 : (shi ? 1 : 0);
         p = s; s = m; m = light_in;
         cyc++;
      end
   end

   always @(negedge clk) begin
      check("mode", 32'(mode), 32'(mode_m));
      check("half_period", 32'(half_period), 32'(hp_m));
      check("period_valid", 32'(period_valid), 32'(pv_m));
      check("mode_changed", 32'(mode_changed), 32'(mc_m));
      n_mc += int'(mode_changed);
      n_pv += int'(period_valid);
   end

   task automatic step(input bit v);
      @(negedge clk);
      #1;
      light_in = v;
   endtask

   task automatic hold(input bit v, input int n);
      repeat (n) step(v);
   endtask

   task automatic toggle(input int per, input int n);
      bit v;
      v = light_in;
      for (int i = 0; i < n; i++) begin
         if (i % per == 0) v = !v;
         step(v);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;

      hold(1'b0, 30);
      check("s1_mode", 32'(mode), 32'(0));
      check("s1_hp", 32'(half_period), 32'(0));
      check("s1_mc_cnt", 32'(n_mc), 32'(0));
      check("s1_pv_cnt", 32'(n_pv), 32'(0));

      snap_mc = n_mc;
      hold(1'b1, 14);
      check("s2_mode", 32'(mode), 32'(1));
      check("s2_mc_cnt", 32'(n_mc - snap_mc), 32'(1));

      snap_mc = n_mc;
      toggle(1, 20);
      check("s3_mode", 32'(mode), 32'(2));
      check("s3_hp", 32'(half_period), 32'(1));
      check("s3_pv", 32'(period_valid), 32'(1));
      check("s3_mc_cnt", 32'(n_mc - snap_mc), 32'(1));

      snap_mc = n_mc;
      toggle(3, 24);
      check("s4_mode", 32'(mode), 32'(2));
      check("s4_hp", 32'(half_period), 32'(3));
      check("s4_mc_cnt", 32'(n_mc - snap_mc), 32'(0));

      snap_mc = n_mc;
      hold(1'b0, 16);
      check("s5_mode", 32'(mode), 32'(0));
      check("s5_hp", 32'(half_period), 32'(3));
      check("s5_mc_cnt", 32'(n_mc - snap_mc), 32'(1));

      toggle(1, 6);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mode", 32'(mode), 32'(0));
      check("rst_hp", 32'(half_period), 32'(0));
      check("rst_pv", 32'(period_valid), 32'(0));
      check("rst_mc", 32'(mode_changed), 32'(0));
      hold(1'b0, 2);
      rst_n = 1'b1;
      snap_mc = n_mc;
      toggle(1, 20);
      check("s6_mode", 32'(mode), 32'(2));
      check("s6_mc_cnt", 32'(n_mc - snap_mc), 32'(1));

      for (int k = 0; k < 60; k++) begin
         hold(!light_in, $urandom_range(1, 12));
      end
      hold(light_in, 12);

      $display("TB_RESULT checks=%0d failures=%0d",
               n_checks, n_fail);
      $finish;
   end

endmodule
